// File: rtl/plic_pkg.sv
// Shared constants for the PLIC target-side blocks: default sizes, ID width helper,
// claim FSM encoding and the reserved "no interrupt" ID.
package plic_pkg;

    localparam int NUM_SRC_DEFAULT = 8;
    localparam int PRIO_W_DEFAULT  = 3;
    localparam int ID_NONE         = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // IDs run 0..num_src, with 0 reserved for "none".
    function automatic int id_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/plic_max_prio.sv
// Combinational max-priority finder over an eligible mask.
// When several sources share the top priority, the lowest ID wins.
module plic_max_prio
    import plic_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int PRIO_W  = PRIO_W_DEFAULT,
    parameter int ID_W    = id_width(NUM_SRC_DEFAULT)
) (
    input  logic [NUM_SRC-1:0]        eligible,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    output logic [ID_W-1:0]           best_id,
    output logic [PRIO_W-1:0]         best_prio
);

    // Ascending scan with a strict compare keeps the first (lowest) ID on ties.
    // Eligible sources always have prio >= 1, so starting from 0 is safe.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_id   = ID_W'(i + 1);
                best_prio = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/plic_target_claim.sv
// Hart-facing PLIC context: selects the winning source, drives eip, and
// serves claim reads and complete writes against an in-service mask.
module plic_target_claim
    import plic_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int PRIO_W  = PRIO_W_DEFAULT,
    parameter int ID_W    = id_width(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        ip,
    input  logic [NUM_SRC-1:0]        ie,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim_req,
    output logic                      claim_valid,
    output logic [ID_W-1:0]           claim_id,
    output logic [NUM_SRC-1:0]        claim,
    input  logic                      complete_req,
    input  logic [ID_W-1:0]           complete_id,
    output logic [NUM_SRC-1:0]        gw_complete,
    output logic                      eip
);

    // Strobe semantics: claim_req and complete_req are single-cycle strobes with no
    // backpressure. A claim accepted in IDLE is answered by exactly one claim_valid
    // cycle (RESP); a claim_req arriving during RESP is dropped.

    logic [0:0]         state;
    logic [ID_W-1:0]    resp_id;
    logic [ID_W-1:0]    best_id_c;
    logic [ID_W-1:0]    best_id_q;
    logic [PRIO_W-1:0]  best_prio_c;
    logic [PRIO_W-1:0]  best_prio_q;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] in_service_next;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] complete_hit;
    logic [NUM_SRC-1:0] claim_set;
    logic               claim_take;
    logic               complete_ok;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = ip[i] && ie[i] && !in_service[i]
                          && (prio[i*PRIO_W +: PRIO_W] > threshold);
        end
    end

    plic_max_prio #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_max_prio (
        .eligible  (eligible),
        .prio      (prio),
        .best_id   (best_id_c),
        .best_prio (best_prio_c)
    );

    assign claim_take  = claim_req && (state == ST_IDLE);
    assign complete_ok = complete_req && (complete_id != ID_W'(ID_NONE))
                         && (complete_id <= ID_W'(NUM_SRC));

    // Completion clears before the claim sets, so both may land in one cycle.
    always_comb begin
        complete_hit = '0;
        claim_set    = '0;
        claim        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            complete_hit[i] = complete_ok && (complete_id == ID_W'(i + 1)) && in_service[i];
            claim_set[i]    = claim_take && (best_id_q == ID_W'(i + 1));
            claim[i]        = (state == ST_RESP) && (resp_id == ID_W'(i + 1));
        end
        in_service_next = (in_service & ~complete_hit) | claim_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            resp_id     <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            in_service  <= '0;
            gw_complete <= '0;
        end else begin
            best_id_q   <= best_id_c;
            best_prio_q <= best_prio_c;
            in_service  <= in_service_next;
            gw_complete <= complete_hit;
            if (state == ST_IDLE) begin
                if (claim_req) begin
                    state   <= ST_RESP;
                    resp_id <= best_id_q;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    assign claim_valid = (state == ST_RESP);
    assign claim_id    = resp_id;
    // A real winner always carries nonzero priority, so the terms agree.
    assign eip         = (best_id_q != ID_W'(ID_NONE)) && (best_prio_q != '0);

endmodule

// File: tb/tb_plic_target_claim.sv
// Directed and randomized bench for plic_target_claim against a source-level
// reference model of claims, completions and the in-service set.
module tb_plic_target_claim;
    import plic_pkg::*;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = id_width(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    ip;
    logic [N-1:0]    ie;
    logic [N*PW-1:0] prio;
    logic [PW-1:0]   threshold;
    logic            claim_req;
    logic            claim_valid;
    logic [IW-1:0]   claim_id;
    logic [N-1:0]    claim;
    logic            complete_req;
    logic [IW-1:0]   complete_id;
    logic [N-1:0]    gw_complete;
    logic            eip;

    plic_target_claim #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ip           (ip),
        .ie           (ie),
        .prio         (prio),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_valid  (claim_valid),
        .claim_id     (claim_id),
        .claim        (claim),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .gw_complete  (gw_complete),
        .eip          (eip)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: set of claimed-but-not-completed sources, the winner seen
    // last cycle, whether a response is being shown and the last claimed ID.
    bit m_ins [1:N];
    int m_best;
    bit m_resp;
    int m_resp_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int prio_of(input int s);
        return int'(prio[(s-1)*PW +: PW]);
    endfunction

    // Highest priority strictly above threshold among pending, enabled,
    // not-in-service sources; lowest ID on ties; 0 when none.
    function automatic int model_best();
        int best = 0;
        int bp   = 0;
        for (int s = 1; s <= N; s++) begin
            if (ip[s-1] && ie[s-1] && !m_ins[s] && prio_of(s) > int'(threshold)) begin
                if (prio_of(s) > bp) begin
                    best = s;
                    bp   = prio_of(s);
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int s = 1; s <= N; s++) m_ins[s] = 1'b0;
        m_best    = 0;
        m_resp    = 1'b0;
        m_resp_id = 0;
    endtask

    task automatic set_prio(input int s, input int v);
        prio[(s-1)*PW +: PW] = PW'(v);
    endtask

    // One clock: predict from the pre-edge inputs, then compare every output.
    task automatic tick();
        int nb;
        int gwn;
        int cid;
        bit rn;
        int rid;
        nb  = model_best();
        gwn = 0;
        cid = int'(complete_id);
        if (complete_req && cid >= 1 && cid <= N && m_ins[cid]) begin
            m_ins[cid] = 1'b0;
            gwn = 1 << (cid - 1);
        end
        rn  = 1'b0;
        rid = m_resp_id;
        if (!m_resp && claim_req) begin
            rn  = 1'b1;
            rid = m_best;
            if (m_best != 0) m_ins[m_best] = 1'b1;
        end
        @(posedge clk);
        #1;
        m_best    = nb;
        m_resp    = rn;
        m_resp_id = rid;
        check("eip", eip, 32'(nb != 0));
        check("claim_valid", claim_valid, 32'(rn));
        check("claim_id", claim_id, rid);
        check("claim", claim, (rn && rid != 0) ? (1 << (rid - 1)) : 0);
        check("gw_complete", gw_complete, gwn);
        claim_req    = 1'b0;
        complete_req = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_req = 1'b1;
        complete_id  = IW'(id);
        tick();
    endtask

    task automatic do_claim();
        claim_req = 1'b1;
        tick();
    endtask

    initial begin
        // Reset with everything pending at top priority
        rst_n        = 1'b0;
        ip           = 8'hFF;
        ie           = 8'hFF;
        prio         = '1;
        threshold    = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        model_reset();
        #2;
        check("rst_eip", eip, 0);
        check("rst_claim_valid", claim_valid, 0);
        check("rst_claim", claim, 0);
        check("rst_gw", gw_complete, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_eip", eip, 0);
        rst_n = 1'b1;
        tick();
        check("rst_release_eip", eip, 1);

        // Single source 3 at prio 5 over threshold 2
        ip = '0; prio = '0; threshold = 3'd2;
        tick(); tick();
        set_prio(3, 5); ip = 8'h04;
        tick();
        check("single_eip", eip, 1);
        do_claim();
        check("single_id", claim_id, 3);
        check("single_claim", claim, 8'h04);
        tick();
        check("single_eip_drop", eip, 0);
        ip = '0;
        tick();
        do_complete(3);
        check("complete_gw", gw_complete, 8'h04);
        tick();
        check("complete_gw_once", gw_complete, 0);
        do_complete(5);
        do_complete(0);
        do_complete(9);
        check("complete_ignored", gw_complete, 0);

        // Tie-break between sources 2 and 6
        prio = '0; set_prio(2, 4); set_prio(6, 4); ip = 8'h22;
        tick();
        do_claim();
        check("tie_first", claim_id, 2);
        tick();
        ip = 8'h20;
        tick();
        do_claim();
        check("tie_second", claim_id, 6);
        check("tie_second_claim", claim, 8'h20);
        tick();

        // Simultaneous claim of 4 and completion of 2
        ip = 8'h08; set_prio(4, 5);
        tick(); tick();
        claim_req = 1'b1; complete_req = 1'b1; complete_id = IW'(2);
        tick();
        check("simul_claim", claim_id, 4);
        check("simul_gw", gw_complete, 8'h02);
        tick();
        ip = '0;
        do_complete(6);
        do_complete(4);

        // Threshold equal to priority masks the source
        prio = '0; set_prio(5, 3); threshold = 3'd3; ip = 8'h10;
        tick(); tick();
        check("thr_eip_low", eip, 0);
        do_claim();
        check("thr_none_id", claim_id, 0);
        check("thr_none_claim", claim, 0);
        tick();
        threshold = 3'd2;
        tick();
        check("thr_eip_high", eip, 1);
        do_claim();
        check("thr_claim", claim_id, 5);
        tick();
        ip = '0;
        do_complete(5);

        // Back-to-back claim strobes yield a single response
        prio = '0; set_prio(7, 6); ip = 8'h40;
        tick(); tick();
        do_claim();
        do_claim();
        check("b2b_second_ignored", claim_valid, 0);
        tick();
        ip = '0;
        do_complete(7);

        // Reset asserted while the response is showing
        prio = '0; set_prio(1, 7); ip = 8'h01;
        tick(); tick();
        do_claim();
        check("rresp_valid", claim_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rresp_valid_clr", claim_valid, 0);
        check("rresp_claim_clr", claim, 0);
        check("rresp_id_clr", claim_id, 0);
        check("rresp_eip_clr", eip, 0);
        @(posedge clk);
        #1;
        check("rresp_hold", claim_valid, 0);
        rst_n = 1'b1;
        ip = '0;
        tick(); tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            ip = N'($urandom);
            ie = N'($urandom);
            prio = (N*PW)'($urandom);
            if ($urandom_range(0, 7) == 0) threshold = PW'($urandom_range(0, 7));
            claim_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                complete_req = 1'b1;
                complete_id  = IW'($urandom_range(0, 10));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
